// File: rtl/anim_sequencer.sv
// Animation sequencer for the pet display sprite ROMs.
// Picks the animation to show by fixed request priority, steps its frame index on a
// prescaled tick, and applies every change only on vsync so a frame never tears.
module anim_sequencer #(
  parameter int unsigned TICK_DIV  = 33554432,
  parameter int unsigned N_STEPS   = 16,
  parameter int unsigned N_ANIM    = 4,
  parameter int unsigned IDLE_ANIM = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_ANIM-1:0]          req,
  input  logic [N_ANIM-1:0]          oneshot,
  input  logic                       vsync_pulse,
  input  logic                       pause,
  output logic [$clog2(N_ANIM)-1:0]  anim_sel,
  output logic [$clog2(N_STEPS)-1:0] step,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = $clog2(N_ANIM);
  localparam int unsigned SW = $clog2(N_STEPS);
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {StLoop, StOneshot, StHold} state_e;

  state_e          r_state, w_state_d;
  logic [AW-1:0]   r_anim, w_anim_d;
  logic [SW-1:0]   r_step, w_step_d;
  logic [PW-1:0]   r_presc, w_presc_d;
  logic            r_pend, w_pend_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;

  logic [AW-1:0]   w_win;
  logic            w_tick;
  logic            w_pend_eff;
  logic            w_switch;

  // Priority pick: highest set request wins, idle animation when nobody asks.
  always_comb begin
    w_win = AW'(IDLE_ANIM);
    for (int i = 0; i < N_ANIM; i++) begin
      if (req[i]) w_win = AW'(i);
    end
  end

  // Next-state logic: prescaler/pending run every cycle, everything visible moves on vsync.
  always_comb begin
    w_tick     = !pause && (r_presc == PW'(TICK_DIV - 1));
    // A tick landing on the vsync cycle is honoured by that vsync.
    w_pend_eff = r_pend | w_tick;
    w_state_d  = r_state;
    w_anim_d   = r_anim;
    w_step_d   = r_step;
    w_done_d   = 1'b0;
    w_switch   = 1'b0;
    w_pend_d   = w_pend_eff;
    if (pause)       w_presc_d = r_presc;
    else if (w_tick) w_presc_d = '0;
    else             w_presc_d = r_presc + 1'b1;

    if (vsync_pulse) begin
      // Every vsync either consumes or discards the pending step.
      w_pend_d = 1'b0;
      unique case (r_state)
        StLoop: begin
          if (w_win != r_anim) begin
            w_switch = 1'b1;
          end else if (w_pend_eff) begin
            w_step_d = (r_step == SW'(N_STEPS - 1)) ? '0 : r_step + 1'b1;
          end
        end
        StOneshot: begin
          // Not preemptible: requests are ignored until the last frame is reached.
          if (w_pend_eff) begin
            w_step_d = r_step + 1'b1;
            if (r_step == SW'(N_STEPS - 2)) begin
              w_done_d  = 1'b1;
              w_state_d = StHold;
            end
          end
        end
        StHold: begin
          if (w_win != r_anim) w_switch = 1'b1;
        end
        default: w_state_d = StLoop;
      endcase

      if (w_switch) begin
        w_anim_d  = w_win;
        w_step_d  = '0;
        w_presc_d = '0;
        w_state_d = (oneshot[w_win] && (w_win != AW'(IDLE_ANIM))) ? StOneshot : StLoop;
      end
    end
    w_busy_d = (w_state_d == StOneshot);
  end

  // State and registered outputs; reset drops straight back to idle step 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StLoop;
      r_anim  <= AW'(IDLE_ANIM);
      r_step  <= '0;
      r_presc <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_anim  <= w_anim_d;
      r_step  <= w_step_d;
      r_presc <= w_presc_d;
      r_pend  <= w_pend_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign anim_sel = r_anim;
  assign step     = r_step;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed scenarios then randomized traffic,
// all compared against a behavioural model of the sequencing rules.
module tb_anim_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned NA = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] oneshot;
  logic       vsync_pulse;
  logic       pause;
  logic [1:0] anim_sel;
  logic [1:0] step;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;

  // Model state: plain integers, phase 0 = looping, 1 = playing once, 2 = holding last frame.
  int m_cnt, m_pend, m_anim, m_step, m_phase, m_done;

  anim_sequencer #(
    .TICK_DIV (TD),
    .N_STEPS  (NS),
    .N_ANIM   (NA),
    .IDLE_ANIM(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .oneshot    (oneshot),
    .vsync_pulse(vsync_pulse),
    .pause      (pause),
    .anim_sel   (anim_sel),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int top_req(input logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_anim = 0; m_step = 0; m_phase = 0; m_done = 0;
  endtask

  // One clock of the sequencing rules, using the inputs present at the edge.
  task automatic model_edge();
    int tick, have_step, w;
    tick      = (!pause && m_cnt == TD - 1) ? 1 : 0;
    have_step = m_pend | tick;
    m_cnt     = pause ? m_cnt : (m_cnt + 1) % TD;
    m_pend    = have_step;
    m_done    = 0;
    if (vsync_pulse) begin
      m_pend = 0;
      w = top_req(req);
      if (m_phase != 1 && w != m_anim) begin
        m_anim  = w;
        m_step  = 0;
        m_cnt   = 0;
        m_phase = (oneshot[w] && w != 0) ? 1 : 0;
      end else if (m_phase == 0 && have_step != 0) begin
        m_step = (m_step + 1) % NS;
      end else if (m_phase == 1 && have_step != 0) begin
        m_step = m_step + 1;
        if (m_step == NS - 1) begin
          m_phase = 2;
          m_done  = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("anim_sel", {6'b0, anim_sel}, 8'(m_anim));
    chk("step",     {6'b0, step},     8'(m_step));
    chk("busy",     {7'b0, busy},     8'(m_phase == 1));
    chk("done",     {7'b0, done},     8'(m_done));
  endtask

  // Called at a falling edge with inputs set; ends at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    vcnt = (vcnt + 1) % 10;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_pulse = (vcnt == 9);
      cyc();
    end
  endtask

  // Runs through the next periodic vsync edge; outputs then show its effect.
  task automatic run_to_vsync();
    bit last;
    do begin
      last = (vcnt == 9);
      vsync_pulse = last;
      cyc();
    end while (!last);
    vsync_pulse = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req = '0; oneshot = '0; vsync_pulse = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    // Idle loop: 0 -> 1 -> 2 -> 3 -> 0
    for (int i = 1; i <= 4; i++) begin
      run_to_vsync();
      chk("idle_step", {6'b0, step}, 8'(i % 4));
    end

    // Priority among loop requesters
    req = 4'b0110;
    run_to_vsync();
    chk("prio_anim2", {6'b0, anim_sel}, 8'd2);
    chk("prio_step0", {6'b0, step}, 8'd0);
    req = 4'b0010;
    run_to_vsync();
    chk("prio_anim1", {6'b0, anim_sel}, 8'd1);

    // One-shot on anim 3, then hold, then release
    oneshot = 4'b1000; req = 4'b1000;
    run_to_vsync();
    chk("os_anim3", {6'b0, anim_sel}, 8'd3);
    chk("os_busy", {7'b0, busy}, 8'd1);
    run_to_vsync();
    run_to_vsync();
    chk("os_step2", {6'b0, step}, 8'd2);
    run_to_vsync();
    chk("os_last_step", {6'b0, step}, 8'd3);
    chk("os_done", {7'b0, done}, 8'd1);
    chk("os_busy_off", {7'b0, busy}, 8'd0);
    run_to_vsync();
    chk("hold_step", {6'b0, step}, 8'd3);
    req = 4'b0000;
    run_to_vsync();
    chk("release_anim", {6'b0, anim_sel}, 8'd0);

    // Higher request during a one-shot waits for the hold
    oneshot = 4'b0100; req = 4'b0100;
    run_to_vsync();
    req = 4'b1100;
    run_to_vsync();
    chk("nopre_anim_a", {6'b0, anim_sel}, 8'd2);
    run_to_vsync();
    run_to_vsync();
    chk("nopre_anim_b", {6'b0, anim_sel}, 8'd2);
    chk("nopre_done", {7'b0, done}, 8'd1);
    run_to_vsync();
    chk("nopre_switch", {6'b0, anim_sel}, 8'd3);
    chk("nopre_step0", {6'b0, step}, 8'd0);

    // Pause freezes stepping
    pause = 1'b1;
    run(30);
    chk("pause_frozen", {6'b0, step}, 8'd0);
    run_to_vsync();
    // Line the only tick up with the vsync cycle
    k = TD - 1 - m_cnt;
    run(9 - k);
    pause = 1'b0;
    run_to_vsync();
    chk("tick_on_vsync", {6'b0, step}, 8'd1);
    run_to_vsync();
    chk("two_ticks_one_step", {6'b0, step}, 8'd2);

    // Asynchronous reset in the middle of a one-shot
    oneshot = 4'b0010; req = 4'b0010;
    run_to_vsync();
    run_to_vsync();
    run_to_vsync();
    chk("pre_reset_step", {6'b0, step}, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anim", {6'b0, anim_sel}, 8'd0);
    chk("async_step", {6'b0, step}, 8'd0);
    chk("async_busy", {7'b0, busy}, 8'd0);
    model_reset();
    vsync_pulse = 1'b0; req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run(12);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if ($urandom_range(15) == 0) oneshot = 4'($urandom);
      pause       = ($urandom_range(5) == 0);
      vsync_pulse = ($urandom_range(3) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
